// File: rtl/divider_pkg.sv
// Shared definitions for the unsigned divider and its shift-add reconstructor.
package divider_pkg;

    // Default operand widths of the paired divider.
    localparam int DIV_NUM_BITS = 8;
    localparam int DIV_DEN_BITS = 8;

    // Handshake FSM states shared by the divider and the reconstructor.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Width of a down-counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiplier_reconstruct_unsigned.sv
// Sequential shift-add unit rebuilding a divider numerator as Q*D + R,
// one quotient bit per enabled clock, with a start/done/error handshake.
module multiplier_reconstruct_unsigned
    import divider_pkg::*;
#(
    parameter int MUL_QUOT_BITS = DIV_NUM_BITS,
    parameter int MUL_DEN_BITS  = DIV_DEN_BITS
) (
    input  logic                                  CLK,
    input  logic                                  SRST,
    input  logic                                  CE,
    input  logic [MUL_QUOT_BITS-1:0]              QUOTENT_IN,
    input  logic [MUL_DEN_BITS-1:0]               DENOMINATOR_IN,
    input  logic [MUL_DEN_BITS-1:0]               REMAINDER_IN,
    output logic [MUL_QUOT_BITS+MUL_DEN_BITS-1:0] NUMERATOR_OUT,
    input  logic                                  start,
    output logic                                  error,
    output logic                                  overflow,
    output logic                                  done
);

    localparam int W     = MUL_QUOT_BITS + MUL_DEN_BITS;
    localparam int CNT_W = cnt_width(MUL_QUOT_BITS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_QUOT_BITS - 1);

    mul_state_t                 state_q, state_d;
    logic [W-1:0]               acc_q, acc_d;
    logic [W-1:0]               mcand_q, mcand_d;
    logic [MUL_QUOT_BITS-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [W-1:0]               num_q, num_d;
    logic                       err_q, err_d;
    logic                       ovf_q, ovf_d;
    logic                       done_q, done_d;

    // Accumulator value after the current partial-product step.
    logic [W-1:0]               acc_step;
    logic                       operands_bad;

    assign acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign operands_bad = (DENOMINATOR_IN == '0) || (REMAINDER_IN >= DENOMINATOR_IN);

    // State and datapath registers; everything holds while CE is low.
    always_ff @(posedge CLK or posedge SRST) begin
        if (SRST) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            num_q    <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (CE) begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Next-state: accept/validate in IDLE or DONE, one shift-add step per CALC edge.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        done_d   = done_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                    num_d  = '0;
                    if (operands_bad) begin
                        // Invalid operands answer immediately with error set.
                        state_d = DONE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = CALC;
                        acc_d    = W'(REMAINDER_IN);
                        mcand_d  = W'(DENOMINATOR_IN);
                        mplier_d = QUOTENT_IN;
                        cnt_d    = CNT_LOAD;
                    end
                end
            end
            CALC: begin
                // start is deliberately ignored here so the operation in flight completes.
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    num_d   = acc_step;
                    ovf_d   = |acc_step[W-1:MUL_QUOT_BITS];
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign NUMERATOR_OUT = num_q;
    assign error         = err_q;
    assign overflow      = ovf_q;
    assign done          = done_q;

endmodule

// File: tb/tb_multiplier_reconstruct_unsigned.sv
// Self-checking bench for multiplier_reconstruct_unsigned at 8/8 widths.
module tb_multiplier_reconstruct_unsigned;

    logic        CLK = 1'b0;
    logic        SRST = 1'b1;
    logic        CE = 1'b1;
    logic [7:0]  QUOTENT_IN = '0;
    logic [7:0]  DENOMINATOR_IN = '0;
    logic [7:0]  REMAINDER_IN = '0;
    logic [15:0] NUMERATOR_OUT;
    logic        start = 1'b0;
    logic        error;
    logic        overflow;
    logic        done;

    int total = 0;
    int bad = 0;

    multiplier_reconstruct_unsigned #(
        .MUL_QUOT_BITS(8),
        .MUL_DEN_BITS (8)
    ) dut (
        .CLK           (CLK),
        .SRST          (SRST),
        .CE            (CE),
        .QUOTENT_IN    (QUOTENT_IN),
        .DENOMINATOR_IN(DENOMINATOR_IN),
        .REMAINDER_IN  (REMAINDER_IN),
        .NUMERATOR_OUT (NUMERATOR_OUT),
        .start         (start),
        .error         (error),
        .overflow      (overflow),
        .done          (done)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain arithmetic on the operand rules.
    function automatic void model(input int q, input int d, input int r,
                                  output int num, output bit err, output bit ovf);
        err = (d == 0) || (r >= d);
        num = err ? 0 : q * d + r;
        ovf = !err && (num >= 256);
    endfunction

    // Issue one request and wait for done; lat counts edges after the accept edge.
    task automatic run_op(input int q, input int d, input int r,
                          output int num, output bit err, output bit ovf, output int lat);
        @(negedge CLK);
        QUOTENT_IN     = 8'(q);
        DENOMINATOR_IN = 8'(d);
        REMAINDER_IN   = 8'(r);
        start          = 1'b1;
        @(posedge CLK);
        #1;
        start          = 1'b0;
        QUOTENT_IN     = 8'($urandom);
        DENOMINATOR_IN = 8'($urandom);
        REMAINDER_IN   = 8'($urandom);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        num = int'(NUMERATOR_OUT);
        err = error;
        ovf = overflow;
    endtask

    task automatic test_reset();
        SRST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({done, error, overflow, NUMERATOR_OUT} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got done=%b err=%b ovf=%b num=%0d want all 0",
                     done, error, overflow, NUMERATOR_OUT);
        end
        @(negedge CLK);
        SRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: done=%b want 0", done);
        end
        $display("reset: outputs cleared");
    endtask

    // Directed vectors from the operand rules, including width extremes and error paths.
    task automatic test_directed();
        int vq[7] = '{25, 255, 0, 5, 5, 1, 255};
        int vd[7] = '{10, 255, 1, 0, 3, 255, 1};
        int vr[7] = '{7, 254, 0, 0, 3, 254, 0};
        for (int i = 0; i < 7; i++) begin
            int num, lat, enum_, elat;
            bit err, ovf, eerr, eovf;
            run_op(vq[i], vd[i], vr[i], num, err, ovf, lat);
            model(vq[i], vd[i], vr[i], enum_, eerr, eovf);
            elat = eerr ? 0 : 8;
            total++;
            if (num !== enum_ || err !== eerr || ovf !== eovf || lat !== elat || done !== 1'b1) begin
                bad++;
                $display("FAIL directed[%0d]: got num=%0d err=%b ovf=%b lat=%0d want num=%0d err=%b ovf=%b lat=%0d",
                         i, num, err, ovf, lat, enum_, eerr, eovf, elat);
            end
            $display("directed q=%0d d=%0d r=%0d -> num=%0d err=%b ovf=%b lat=%0d",
                     vq[i], vd[i], vr[i], num, err, ovf, lat);
        end
    endtask

    // CE low for 3 cycles mid-CALC plus a start pulse during CALC.
    task automatic test_ce_and_start_in_calc();
        int lat;
        @(negedge CLK);
        QUOTENT_IN = 8'd12; DENOMINATOR_IN = 8'd17; REMAINDER_IN = 8'd16;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            CE    = !(lat >= 3 && lat < 6);
            start = (lat == 1);
            if (lat == 1) begin
                QUOTENT_IN = 8'd99; DENOMINATOR_IN = 8'd5; REMAINDER_IN = 8'd2;
            end
            @(posedge CLK);
            #1;
            lat++;
        end
        CE = 1'b1;
        start = 1'b0;
        total++;
        if (lat !== 11 || NUMERATOR_OUT !== 16'd220 || error !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ce_stall: got lat=%0d num=%0d err=%b ovf=%b want lat=11 num=220 err=0 ovf=0",
                     lat, NUMERATOR_OUT, error, overflow);
        end
        // With CE low in DONE, a held start must not retrigger.
        @(negedge CLK);
        CE = 1'b0; start = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (done !== 1'b1 || NUMERATOR_OUT !== 16'd220) begin
            bad++;
            $display("FAIL ce_hold_done: got done=%b num=%0d want done=1 num=220", done, NUMERATOR_OUT);
        end
        @(negedge CLK);
        start = 1'b0; CE = 1'b1;
        $display("ce_stall: num=%0d lat=%0d", NUMERATOR_OUT, lat);
    endtask

    task automatic test_reset_mid_calc();
        int num, lat;
        bit err, ovf;
        @(negedge CLK);
        QUOTENT_IN = 8'd200; DENOMINATOR_IN = 8'd200; REMAINDER_IN = 8'd100;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        SRST = 1'b1;
        #1;
        total++;
        if ({done, error, overflow, NUMERATOR_OUT} !== 19'd0) begin
            bad++;
            $display("FAIL reset_mid_calc: got done=%b err=%b ovf=%b num=%0d want all 0",
                     done, error, overflow, NUMERATOR_OUT);
        end
        @(negedge CLK);
        SRST = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done: done=%b want 0", done);
        end
        run_op(3, 4, 1, num, err, ovf, lat);
        total++;
        if (num !== 13 || err !== 1'b0 || ovf !== 1'b0 || lat !== 8) begin
            bad++;
            $display("FAIL after_reset: got num=%0d err=%b ovf=%b lat=%0d want num=13 err=0 ovf=0 lat=8",
                     num, err, ovf, lat);
        end
        $display("reset_mid_calc: follow-up num=%0d", num);
    endtask

    // start held high: a second request is accepted in the DONE cycle.
    task automatic test_back_to_back();
        int lat;
        @(negedge CLK);
        QUOTENT_IN = 8'd7; DENOMINATOR_IN = 8'd9; REMAINDER_IN = 8'd4;
        start = 1'b1;
        @(posedge CLK);
        #1;
        QUOTENT_IN = 8'd40; DENOMINATOR_IN = 8'd6; REMAINDER_IN = 8'd5;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        total++;
        if (lat !== 8 || NUMERATOR_OUT !== 16'd67) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d num=%0d want lat=8 num=67", lat, NUMERATOR_OUT);
        end
        @(posedge CLK);
        #1;
        start = 1'b0;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: done=%b want 0 after re-accept", done);
        end
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        total++;
        if (lat !== 8 || NUMERATOR_OUT !== 16'd245 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d num=%0d ovf=%b want lat=8 num=245 ovf=0",
                     lat, NUMERATOR_OUT, overflow);
        end
        $display("back_to_back: second num=%0d", NUMERATOR_OUT);
    endtask

    // Random operands (valid and invalid mixed) against the model.
    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int q, d, r, num, lat, enum_;
            bit err, ovf, eerr, eovf;
            q = int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 255));
            r = (i % 5 == 0) ? int'($urandom_range(0, 255))
                             : ((d == 0) ? 0 : int'($urandom_range(0, d - 1)));
            run_op(q, d, r, num, err, ovf, lat);
            model(q, d, r, enum_, eerr, eovf);
            total++;
            if (num !== enum_ || err !== eerr || ovf !== eovf || lat !== (eerr ? 0 : 8)) begin
                bad++;
                $display("FAIL random[%0d]: q=%0d d=%0d r=%0d got num=%0d err=%b ovf=%b lat=%0d want num=%0d err=%b ovf=%b",
                         i, q, d, r, num, err, ovf, lat, enum_, eerr, eovf);
            end
            $display("random q=%0d d=%0d r=%0d -> num=%0d err=%b ovf=%b", q, d, r, num, err, ovf);
        end
    endtask

    // Round trip: divide a random numerator, rebuild it, expect the original back.
    task automatic test_round_trip();
        for (int i = 0; i < 300; i++) begin
            int n, d, num, lat;
            bit err, ovf;
            n = int'($urandom_range(0, 255));
            d = int'($urandom_range(1, 255));
            if (i == 0) begin n = 255; d = 1; end
            if (i == 1) begin n = 0; d = 255; end
            run_op(n / d, d, n % d, num, err, ovf, lat);
            total++;
            if (num !== n || err !== 1'b0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL round_trip[%0d]: n=%0d d=%0d got num=%0d err=%b ovf=%b want num=%0d err=0 ovf=0",
                         i, n, d, num, err, ovf, n);
            end
            $display("round_trip n=%0d d=%0d -> num=%0d", n, d, num);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ce_and_start_in_calc();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplier_reconstruct_unsigned.md
# multiplier_reconstruct_unsigned

Sequential unsigned shift-add unit that inverts the unsigned divider. It takes a quotient, denominator and remainder and rebuilds the numerator as `Q*D + R`, one quotient bit per cycle. It uses the divider's `start`/`done`/`error` handshake. It sits beside the divider for round-trip self-checking and for datapaths that rescale divided values.

## Interface
- `MUL_QUOT_BITS`, default 8: quotient width; equals the paired divider's numerator width.
- `MUL_DEN_BITS`, default 8: denominator and remainder width.
- `CLK` in, 1: single clock; all state changes on the rising edge.
- `SRST` in, 1: reset, asynchronous and active-high.
- `CE` in, 1: clock enable; when low, all state and outputs hold.
- `QUOTENT_IN` in, `MUL_QUOT_BITS`: unsigned quotient operand.
- `DENOMINATOR_IN` in, `MUL_DEN_BITS`: unsigned denominator operand.
- `REMAINDER_IN` in, `MUL_DEN_BITS`: unsigned remainder operand.
- `NUMERATOR_OUT` out, `MUL_QUOT_BITS+MUL_DEN_BITS`: reconstructed numerator; valid while `done`=1.
- `start` in, 1: request; sampled only when `CE`=1 and state is IDLE or DONE.
- `error` out, 1: invalid operands (D==0 or R>=D); valid while `done`=1.
- `overflow` out, 1: result ≥ 2^`MUL_QUOT_BITS`, i.e. not representable as a divider numerator; valid while `done`=1.
- `done` out, 1: result ready; level signal held until the next accepted `start`.

## Operation
- States: IDLE, CALC, DONE.
- **Reset:** state=IDLE. `NUMERATOR_OUT`=0, `done`=0, `error`=0, `overflow`=0, and all internal registers cleared.
- **Accept:** `start`=1 with `CE`=1 in IDLE or DONE.
  - Operands are latched.
  - `done`, `error` and `overflow` clear on the same edge.
- **Invalid operands:** if D==0 or R>=D, go straight to DONE with `error`=1, `NUMERATOR_OUT`=0 and `overflow`=0.
- **Valid operands:**
  - Load: acc=R (zero-extended), mcand=D (zero-extended to full width), mplier=Q, bit counter=`MUL_QUOT_BITS`-1.
  - Go to CALC.
- **CALC, each `CE` edge:**
  - If mplier[0], acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, counter decrements.
  - On the edge where the counter is 0, go to DONE. `NUMERATOR_OUT` takes the final acc; `overflow` = |acc[top `MUL_DEN_BITS` bits].
- **Width rule:** acc is exactly `MUL_QUOT_BITS+MUL_DEN_BITS` bits and never wraps, since (2^Q−1)(2^D−1)+2^D−2 < 2^(Q+D). No carry-out bit is required.
- **`start` during CALC:** ignored; the operation in flight completes unaltered.
- **Operand inputs:** may change freely after the accepting edge.
- **`start` held high:** in DONE, a held `start` re-triggers on the next `CE` edge.
- **Reset mid-CALC:** immediate return to reset values; no `done` pulse.

## Timing
- **Accept edge:** edge 0 is the edge that accepts `start`.
- **Valid operands:** CALC runs on edges 1..`MUL_QUOT_BITS`, so `done`=1 after edge `MUL_QUOT_BITS` (8 cycles at default width).
- **Invalid operands:** `done`=1 and `error`=1 after edge 0 (1-cycle latency).
- **`CE` low:** stretches latency by the number of disabled cycles; the counter does not advance.
- **Outputs:** all are registered; no combinational path from inputs to outputs.
- **Back-to-back throughput:** one result per `MUL_QUOT_BITS`+1 cycles, with `start` held or re-asserted in the DONE cycle.

## Structure
- Shared package `divider_pkg` holds:
  - the state enum typedef `mul_state_t` (IDLE/CALC/DONE), shared with the divider's FSM typedef;
  - the default width constants `DIV_NUM_BITS`/`DIV_DEN_BITS` = 8.
- Single module; no sub-module is warranted. The counter and the shift-add step stay inline.

## Test plan
1. **Basic reconstruction:** Q=25, D=10, R=7, start → after 8 cycles `done`=1, `NUMERATOR_OUT`=257, `overflow`=1, `error`=0.
2. **Extremes:**
   - Q=255, D=255, R=254 → `NUMERATOR_OUT`=65279, `overflow`=1.
   - Q=0, D=1, R=0 → `NUMERATOR_OUT`=0, `overflow`=0.
3. **Error paths:**
   - Q=5, D=0, R=0 → `done`=1 and `error`=1 one cycle after start, `NUMERATOR_OUT`=0.
   - Q=5, D=3, R=3 → same response.
4. **`CE` and `start` during CALC:** Q=12, D=17, R=16 with `CE` low for 3 cycles mid-CALC and `start` pulsed during CALC → `done` after 11 cycles, `NUMERATOR_OUT`=220, no restart.
5. **Reset mid-operation:** `SRST` asserted at CALC cycle 4 → all outputs 0 immediately, state IDLE. A following start with Q=3, D=4, R=1 → 13.
6. **Round trip:** exhaustive 8/8 sweep through the unsigned divider, then this block, for every num and den≠0 → `NUMERATOR_OUT`==num, `overflow`=0, `error`=0.
